alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter OPCODE_W, default 5, opcode field width.
REQ-002 Parameter FUNCT_W, default 5, funct field width.
REQ-003 Parameter OP_W, default 5, ALU operation code width; SHALL be >= FUNCT_W.
REQ-004 Parameter MUL_CODE, default 8, operation code executed as multi-cycle.
REQ-005 Parameter DIV_CODE, default 9, operation code executed as multi-cycle.
REQ-006 Parameter MULTI_LAT, default 4, busy cycles for a multi-cycle op; SHALL be >= 1.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 in_valid  input  1  opcode/funct present.
REQ-011 in_ready  output  1  block accepts opcode/funct this cycle.
REQ-012 opcode  input  OPCODE_W  instruction opcode.
REQ-013 funct  input  FUNCT_W  instruction function field.
REQ-014 op_valid  output  1  operation is valid.
REQ-015 op_ready  input  1  ALU consumes operation.
REQ-016 operation  output  OP_W  registered ALU operation code.
REQ-017 busy  output  1  multi-cycle op in progress.
REQ-018 done  output  1  one-cycle pulse at end of multi-cycle op.
REQ-019 illegal  output  1  one-cycle pulse on undecodable opcode.
REQ-020 illegal_cnt  output  8  saturating count of illegal opcodes.

Function
REQ-021 Decode: opcode 0 (R-type) and opcode 1 (I-type) -> operation = zero-extended funct.
REQ-022 Decode: opcode 2 (load) and 3 (store) -> operation 0 (ADD).
REQ-023 Decode: opcode 4 (branch) -> operation 1 (SUB).
REQ-024 Any other opcode is illegal: no op_valid, illegal=1 next cycle, illegal_cnt +1 saturating at 255, operation unchanged.
REQ-025 Accept = in_valid & in_ready; decoded result registered, op_valid=1 the cycle after accept (latency 1).
REQ-026 FSM states IDLE, ISSUE, MULTI.
REQ-027 IDLE: in_ready=1, op_valid=0; legal accept -> ISSUE; illegal accept -> stay IDLE.
REQ-028 ISSUE: op_valid=1; operation and op_valid held stable until op_ready=1.
REQ-029 ISSUE, op_ready=1, single-cycle op: in_ready=1 same cycle; new legal accept -> stay ISSUE with new op; otherwise -> IDLE.
REQ-030 ISSUE, op_ready=1, operation==MUL_CODE or DIV_CODE: in_ready=0 that cycle; -> MULTI, counter loaded MULTI_LAT-1.
REQ-031 MULTI: busy=1, op_valid=0, in_ready=0; counter decrements each cycle; at 0, done=1 for that cycle and -> IDLE.
REQ-032 ISSUE with op_ready=0: in_ready=0; in_valid ignored.
REQ-033 Opcode/funct wider values compared at full width; opcode 0..4 decode independent of OPCODE_W.

Reset
REQ-034 rst=1 at any clock edge -> IDLE, op_valid=0, busy=0, done=0, illegal=0, operation=0, illegal_cnt=0, counter=0, regardless of state (including mid-MULTI).
REQ-035 in_ready SHALL be 0 during any cycle rst=1 and 1 in the first cycle after rst deasserts.

Verification
REQ-036 opcode=0, funct=0, in_valid 1 cycle, op_ready=1 -> next cycle op_valid=1, operation=0; following cycle op_valid=0.
REQ-037 opcode=1, funct=4, op_ready=0 for 3 cycles -> operation=4 held, op_valid=1, in_ready=0 for all 3 cycles; released on op_ready=1.
REQ-038 opcode=0, funct=8, op_ready=1 -> operation=8, then busy=1 for 4 cycles, done=1 on 4th, in_ready=1 after.
REQ-039 opcode=7 -> illegal=1 one cycle, op_valid stays 0, illegal_cnt=1; 300 illegal opcodes -> illegal_cnt=255.
REQ-040 Back-to-back opcode=2 then opcode=4 with op_ready=1 -> operation 0 then 1 on consecutive cycles, op_valid continuous.
REQ-041 rst=1 on second MULTI cycle -> next cycle busy=0, done=0, op_valid=0, in_ready=0; then in_ready=1.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// Instruction-in / ALU-operation-out handshake bundle for alu_ctrl_seq.
interface alu_ctrl_seq_if #(
  parameter int OPCODE_W = 5,
  parameter int FUNCT_W  = 5,
  parameter int OP_W     = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                op_valid;
  logic                op_ready;
  logic [OP_W-1:0]     operation;
  logic                busy;
  logic                done;
  logic                illegal;
  logic [7:0]          illegal_cnt;

  modport master (
    output in_valid, opcode, funct, op_ready,
    input  in_ready, op_valid, operation, busy, done, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, opcode, funct, op_ready,
    output in_ready, op_valid, operation, busy, done, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Decodes opcode/funct into a registered ALU op (1-cycle latency); holds op until op_ready,
// stalls intake (in_ready=0) while waiting or during a MULTI_LAT-cycle mul/div.
module alu_ctrl_seq #(
  parameter int OPCODE_W  = 5,
  parameter int FUNCT_W   = 5,
  parameter int OP_W      = 5,
  parameter int MUL_CODE  = 8,
  parameter int DIV_CODE  = 9,
  parameter int MULTI_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_ctrl_seq_if.slave bus
);
  localparam int XW    = OPCODE_W + 3;
  localparam int CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, MULTI} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0] operation_q;
  logic            op_valid_q;
  logic            busy_q;
  logic            done_q;
  logic            illegal_q;
  logic [7:0]      illegal_cnt_q;

  logic [XW-1:0]   opc_x;
  logic            dec_legal;
  logic [OP_W-1:0] dec_op;
  logic            is_multi;
  logic            in_ready;
  logic            accept;

  // Widen opcode so codes 0..4 match even when OPCODE_W < 3.
  assign opc_x = {3'b000, bus.opcode};

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = '0;
    if (opc_x == XW'(0) || opc_x == XW'(1)) begin
      dec_op = OP_W'(bus.funct);
    end else if (opc_x == XW'(2) || opc_x == XW'(3)) begin
      dec_op = '0;
    end else if (opc_x == XW'(4)) begin
      dec_op = OP_W'(1);
    end else begin
      dec_legal = 1'b0;
    end
  end

  assign is_multi = (operation_q == OP_W'(MUL_CODE)) || (operation_q == OP_W'(DIV_CODE));
  assign in_ready = !rst && ((state == IDLE) ||
                             (state == ISSUE && bus.op_ready && !is_multi));
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      operation_q   <= '0;
      op_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      illegal_q <= 1'b0;
      if (accept && !dec_legal) begin
        illegal_q <= 1'b1;
        if (illegal_cnt_q != 8'hFF) illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end

      case (state)
        IDLE: begin
          if (accept && dec_legal) begin
            operation_q <= dec_op;
            op_valid_q  <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.op_ready) begin
            if (is_multi) begin
              op_valid_q <= 1'b0;
              busy_q     <= 1'b1;
              cnt        <= CNT_W'(MULTI_LAT - 1);
              done_q     <= (MULTI_LAT == 1);
              state      <= MULTI;
            end else if (accept && dec_legal) begin
              operation_q <= dec_op;
            end else begin
              op_valid_q <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        MULTI: begin
          if (cnt == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt    <= cnt - CNT_W'(1);
            done_q <= (cnt == CNT_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.op_valid    = op_valid_q;
  assign bus.operation   = operation_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with hand-computed expectations.
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.OPCODE_W(5), .FUNCT_W(5), .OP_W(5)) bus ();

  alu_ctrl_seq #(
    .OPCODE_W(5), .FUNCT_W(5), .OP_W(5),
    .MUL_CODE(8), .DIV_CODE(9), .MULTI_LAT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.funct    = '0;
    bus.op_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_operation", bus.operation, 0);
    chk("rst_illegal_cnt", bus.illegal_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // R-type ADD, consumed immediately
    bus.opcode = 5'd0; bus.funct = 5'd0; bus.in_valid = 1'b1; bus.op_ready = 1'b1;
    #1;
    chk("add_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("add_op_valid", bus.op_valid, 1);
    chk("add_operation", bus.operation, 0);
    chk("add_in_ready_issue", bus.in_ready, 1);
    tick();
    chk("add_op_valid_drop", bus.op_valid, 0);

    // I-type funct 4 held under backpressure; in_valid ignored meanwhile
    bus.opcode = 5'd1; bus.funct = 5'd4; bus.in_valid = 1'b1; bus.op_ready = 1'b0;
    tick();
    bus.opcode = 5'd4; bus.funct = 5'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_op_valid", bus.op_valid, 1);
      chk("hold_operation", bus.operation, 4);
      chk("hold_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.op_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_operation", bus.operation, 4);
    tick();
    chk("release_op_valid", bus.op_valid, 0);

    // MUL: 4 busy cycles, done on the last
    bus.opcode = 5'd0; bus.funct = 5'd8; bus.in_valid = 1'b1; bus.op_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("mul_op_valid", bus.op_valid, 1);
    chk("mul_operation", bus.operation, 8);
    chk("mul_in_ready_issue", bus.in_ready, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy", bus.busy, 1);
      chk("mul_done", bus.done, (i == 3) ? 1 : 0);
      chk("mul_op_valid_multi", bus.op_valid, 0);
      chk("mul_in_ready_multi", bus.in_ready, 0);
      tick();
    end
    chk("mul_busy_end", bus.busy, 0);
    chk("mul_done_end", bus.done, 0);
    chk("mul_in_ready_end", bus.in_ready, 1);

    // Back-to-back load then branch
    bus.opcode = 5'd2; bus.funct = 5'd31; bus.in_valid = 1'b1; bus.op_ready = 1'b1;
    tick();
    bus.opcode = 5'd4;
    #1;
    chk("b2b_op_valid0", bus.op_valid, 1);
    chk("b2b_operation0", bus.operation, 0);
    chk("b2b_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_op_valid1", bus.op_valid, 1);
    chk("b2b_operation1", bus.operation, 1);
    tick();
    chk("b2b_op_valid_drop", bus.op_valid, 0);

    // Illegal opcode: pulse, no op, operation unchanged
    bus.opcode = 5'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("ill_pulse", bus.illegal, 1);
    chk("ill_op_valid", bus.op_valid, 0);
    chk("ill_cnt1", bus.illegal_cnt, 1);
    chk("ill_operation", bus.operation, 1);
    chk("ill_in_ready", bus.in_ready, 1);
    tick();
    chk("ill_pulse_end", bus.illegal, 0);

    // 300 more illegal opcodes saturate the counter
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.opcode = 5'(5 + (i % 27));
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("ill_cnt_sat", bus.illegal_cnt, 255);
    chk("ill_sat_op_valid", bus.op_valid, 0);
    tick();
    chk("ill_cnt_hold", bus.illegal_cnt, 255);

    // DIV, then reset during the second MULTI cycle
    bus.opcode = 5'd1; bus.funct = 5'd9; bus.in_valid = 1'b1; bus.op_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("div_operation", bus.operation, 9);
    chk("div_in_ready_issue", bus.in_ready, 0);
    tick();
    chk("div_busy1", bus.busy, 1);
    tick();
    chk("div_busy2", bus.busy, 1);
    chk("div_done2", bus.done, 0);
    rst = 1'b1;
    tick();
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_op_valid", bus.op_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_operation", bus.operation, 0);
    chk("midrst_illegal_cnt", bus.illegal_cnt, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", bus.in_ready, 1);
    tick();
    chk("midrst_idle_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
